// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 16x-clocked uart_tx among NUM_REQ byte requesters.
// Optional per-frame watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic [ID_W-1:0]      o_grant_id,
    output logic                 o_timeout
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_ACC, S_WAIT_BUSY, S_WAIT_END, S_GAP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ID_W-1:0]      r_ptr, r_grant_id, w_win;
    logic [7:0]           r_tx_data, w_byte;
    logic [NUM_REQ-1:0]   r_ack;
    logic [GW-1:0]        r_gap_cnt;
    logic                 w_found, w_ack_set, w_grant, w_wait;
    logic [IW-1:0]        w_i, w_sel;
    int                   w_t;

    // Walk offsets from farthest to nearest so the nearest set bit after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_t     = 0;
        w_i     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_t = (int'(r_ptr) + off) % NUM_REQ;
            w_i = IW'(w_t);
            if (i_req[w_i]) begin
                w_found = 1'b1;
                w_sel   = w_i;
            end
        end
        w_win  = ID_W'(w_sel);
        w_byte = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (w_sel == IW'(k)) w_byte = i_req_data[8*k +: 8];
    end

    assign w_grant = (r_state == S_IDLE) && w_found;
    assign w_wait  = (r_state == S_WAIT_ACC) || (r_state == S_WAIT_BUSY) ||
                     (r_state == S_WAIT_END);

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [11:0] r_wdog;
    logic        r_timeout, w_to;

    assign w_to = w_wait && (r_wdog == 12'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to;
            if (w_grant)     r_wdog <= '0;
            else if (w_wait) r_wdog <= r_wdog + 12'd1;
        end
    end
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ack_set   = 1'b0;
        case (r_state)
            S_IDLE:      if (w_found) w_state_nxt = S_START;
            S_START:     w_state_nxt = S_WAIT_ACC;
            S_WAIT_ACC:  if (i_tx_done) w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!i_tx_done) w_state_nxt = S_WAIT_END;
            S_WAIT_END:
                if (i_tx_done) begin
                    w_state_nxt = S_GAP;
                    w_ack_set   = 1'b1;
                end
            S_GAP:       if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog abort: skip the ack, keep the pointer so rotation moves on.
        if (w_to) begin
            w_state_nxt = S_GAP;
            w_ack_set   = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_ack      <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_set ? (NUM_REQ'(1) << r_grant_id) : '0;
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
            else                  r_gap_cnt <= '0;
            if (w_grant) begin
                r_tx_data  <= w_byte;
                r_grant_id <= w_win;
                r_ptr      <= w_win;
            end
        end
    end

    assign o_ack      = r_ack;
    assign o_tx_start = (r_state == S_START);
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != S_IDLE);
    assign o_grant_id = r_grant_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int TO   = 100;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [3:0]  i_req = '0;
    logic [31:0] i_req_data = '0;
    logic        i_tx_done = 1'b0;
    logic [3:0]  o_ack;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic [1:0]  o_grant_id;
    logic        o_timeout;

    int vecs = 0;
    int errs = 0;
    int ptr_m = NREQ - 1;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .ID_W(2), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_req_data(i_req_data),
        .o_ack(o_ack), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_grant_id(o_grant_id), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Reference: first requester strictly after the last grant, wrapping around.
    function automatic int rr_pick(input int ptr, input logic [3:0] req);
        for (int off = 1; off <= NREQ; off++)
            if (req[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        return -1;
    endfunction

    // One full frame through a behavioural transmitter: done 1 (accept), 0 (busy), 1 (end).
    task automatic run_frame(input int drop_id, input logic [7:0] new_byte, input bit chg, input bit hold);
        int exp_id, n, len;
        logic [7:0] exp_d;
        exp_id = rr_pick(ptr_m, i_req);
        exp_d  = i_req_data[8*exp_id +: 8];
        n = 0;
        while (!o_tx_start && n < 64) begin tick; n++; end
        vecs++;
        if (o_tx_start !== 1'b1) begin
            errs++; $display("FAIL start_seen got=%b exp=1", o_tx_start); return;
        end
        vecs++;
        if (o_grant_id !== 2'(exp_id)) begin errs++; $display("FAIL grant_id got=%0d exp=%0d", o_grant_id, exp_id); end
        vecs++;
        if (o_tx_data !== exp_d) begin errs++; $display("FAIL tx_data got=%h exp=%h", o_tx_data, exp_d); end
        vecs++;
        if (o_busy !== 1'b1) begin errs++; $display("FAIL busy_at_start got=%b exp=1", o_busy); end
        ptr_m = exp_id;
        if (chg) i_req_data[8*exp_id +: 8] = new_byte;
        tick;
        vecs++;
        if (o_tx_start !== 1'b0) begin errs++; $display("FAIL start_width got=%b exp=0", o_tx_start); end
        tick;
        i_tx_done = 1'b1;
        repeat ($urandom_range(1, 3)) tick;
        i_tx_done = 1'b0;
        len = $urandom_range(3, 20);
        for (int k = 0; k < len; k++) begin
            if (k == 1 && drop_id >= 0) i_req[drop_id] = 1'b0;
            tick;
            vecs++;
            if (o_tx_data !== exp_d || o_ack !== 4'b0) begin
                errs++; $display("FAIL mid_frame data=%h ack=%b exp data=%h ack=0000", o_tx_data, o_ack, exp_d);
            end
        end
        i_tx_done = 1'b1;
        tick;
        vecs++;
        if (o_ack !== 4'(1 << exp_id)) begin errs++; $display("FAIL ack got=%b exp=%b", o_ack, 4'(1 << exp_id)); end
        vecs++;
        if (o_busy !== 1'b1) begin errs++; $display("FAIL busy_at_ack got=%b exp=1", o_busy); end
        i_tx_done = 1'b0;
        if (!hold) i_req[exp_id] = 1'b0;
        tick;
        vecs++;
        if (o_ack !== 4'b0) begin errs++; $display("FAIL ack_width got=%b exp=0000", o_ack); end
        n = 1;
        while (o_busy && n < 100) begin
            vecs++;
            if (o_tx_start !== 1'b0) begin errs++; $display("FAIL start_in_gap got=1 exp=0"); end
            tick; n++;
        end
        vecs++;
        if (n != GAP) begin errs++; $display("FAIL gap_len got=%0d exp=%0d", n, GAP); end
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0;
        tick; tick;
        vecs++;
        if ({o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout} !== 17'b0) begin
            errs++; $display("FAIL reset_outputs got=%h exp=0", {o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout});
        end
        i_reset_n = 1'b1;
        tick;
        vecs++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin errs++; $display("FAIL idle_after_reset busy=%b start=%b exp 0 0", o_busy, o_tx_start); end
    endtask

    task automatic test_single;
        i_req_data = $urandom;
        i_req_data[23:16] = 8'hA5;
        i_req = 4'b0100;
        run_frame(-1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        i_req_data = $urandom;
        i_req = 4'b1111;
        for (int f = 0; f < 5; f++) run_frame(-1, 8'h00, 1'b0, 1'b1);
        i_req = 4'b0000;
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            i_req = i_req | 4'($urandom_range(1, 15));
            i_req_data = $urandom;
            run_frame(-1, 8'h00, 1'b0, 1'b0);
        end
        i_req = 4'b0000;
    endtask

    task automatic test_data_change;
        i_req_data[15:8] = 8'h3C;
        i_req = 4'b0010;
        run_frame(-1, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_req_drop;
        i_req_data[31:24] = 8'h5A;
        i_req = 4'b1000;
        run_frame(3, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int n;
        i_req = 4'b0100;
        n = 0;
        while (!o_tx_start && n < 64) begin tick; n++; end
        tick; i_tx_done = 1'b1;
        tick; tick; i_tx_done = 1'b0;
        tick; tick;
        i_reset_n = 1'b0;
        #1;
        vecs++;
        if ({o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout} !== 17'b0) begin
            errs++; $display("FAIL reset_mid_outputs got=%h exp=0", {o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout});
        end
        i_req = 4'b1111;
        i_req_data = $urandom;
        ptr_m = NREQ - 1;
        tick; tick;
        vecs++;
        if (o_ack !== 4'b0 || o_busy !== 1'b0) begin errs++; $display("FAIL reset_hold ack=%b busy=%b exp 0 0", o_ack, o_busy); end
        i_reset_n = 1'b1;
        run_frame(-1, 8'h00, 1'b0, 1'b0);
        i_req = 4'b0000;
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n, exp_id;
        bit acked;
        i_req = 4'b0110;
        i_req_data = $urandom;
        exp_id = rr_pick(ptr_m, i_req);
        n = 0;
        while (!o_tx_start && n < 64) begin tick; n++; end
        vecs++;
        if (o_grant_id !== 2'(exp_id)) begin errs++; $display("FAIL to_grant got=%0d exp=%0d", o_grant_id, exp_id); end
        ptr_m = exp_id;
        n = 0; acked = 0;
        while (!o_timeout && n < 300) begin tick; n++; if (o_ack !== 4'b0) acked = 1; end
        vecs++;
        if (n < TO - 5 || n > TO + 5) begin errs++; $display("FAIL to_latency got=%0d exp=~%0d", n, TO); end
        vecs++;
        if (acked) begin errs++; $display("FAIL to_ack got=1 exp=0"); end
        tick;
        vecs++;
        if (o_timeout !== 1'b0) begin errs++; $display("FAIL to_width got=%b exp=0", o_timeout); end
        n = 0;
        while (o_busy && n < 100) begin tick; n++; if (o_ack !== 4'b0) acked = 1; end
        vecs++;
        if (acked || o_busy) begin errs++; $display("FAIL to_gap ack=%b busy=%b exp 0 0", acked, o_busy); end
        run_frame(-1, 8'h00, 1'b0, 1'b0);
        i_req = 4'b0000;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_data_change;
        test_req_drop;
        test_random;
        test_reset_mid;
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
